// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dmem_pkg
// Brief    : Shared types and sizing helpers for the data memory responder.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    localparam int c_byte_lanes = 4;

    // Counter only has to hold LATENCY-1, but never narrower than one bit.
    function automatic int cnt_width(input int latency);
        return (latency <= 2) ? 1 : $clog2(latency);
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_array
// Brief    : DEPTH_WORDS x 32 word array, combinational read, byte-lane write.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           clock,
    input  logic [c_byte_lanes-1:0]        lane_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    assign rdata = r_mem[addr];

    always_ff @(posedge clock) begin
        for (int i = 0; i < c_byte_lanes; i++) begin
            if (lane_we[i]) begin
                r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Brief    : Fixed-latency load/store responder over valid/ready handshakes.
//            Define DMEM_BYTE_ENABLE_EN to honour reqByteEn on stores.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqWdata,
    input  logic [3:0]  reqByteEn,
    output logic        rspValid,
    input  logic        rspReady,
    output logic [31:0] rspRdata,
    output logic        rspError
);

    localparam int ADDR_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W  = cnt_width(LATENCY);
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(LATENCY - 1);

    dmem_state_e             r_state;
    dmem_state_e             w_next_state;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_write;
    logic                    r_err;
    logic [ADDR_W-1:0]       r_word_idx;
    logic [31:0]             r_wdata;
    logic [c_byte_lanes-1:0] r_byte_en;
    logic [c_byte_lanes-1:0] w_req_be;
    logic [c_byte_lanes-1:0] w_lane_we;
    logic [31:0]             w_rdata;
    logic                    w_addr_err;
    logic                    w_accept;
    logic                    w_commit;

`ifdef DMEM_BYTE_ENABLE_EN
    assign w_req_be = reqByteEn;
`else
    // Full-word stores: the OR with all-ones keeps the port connected but inert.
    assign w_req_be = reqByteEn | {c_byte_lanes{1'b1}};
`endif

    assign w_addr_err = (reqAddr[1:0] != 2'b00) ||
                        ({2'b00, reqAddr[31:2]} >= 32'(DEPTH_WORDS));

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (reqValid)       w_next_state = BUSY;
            BUSY:    if (r_cnt == '0)    w_next_state = RESP;
            RESP:    if (rspReady)       w_next_state = IDLE;
            default:                     w_next_state = IDLE;
        endcase
    end

    always_comb begin
        reqReady = (r_state == IDLE);
        rspValid = (r_state == RESP);
        w_accept = (r_state == IDLE) && reqValid;
        w_commit = (r_state == BUSY) && (r_cnt == '0);
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_cnt      <= '0;
            r_write    <= 1'b0;
            r_err      <= 1'b0;
            r_word_idx <= '0;
            r_wdata    <= '0;
            r_byte_en  <= '0;
            rspRdata   <= '0;
            rspError   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt      <= c_cnt_load;
                r_write    <= reqWrite;
                r_err      <= w_addr_err;
                r_word_idx <= reqAddr[ADDR_W+1:2];
                r_wdata    <= reqWdata;
                r_byte_en  <= w_req_be;
            end else if ((r_state == BUSY) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            if (w_commit) begin
                rspRdata <= (r_write || r_err) ? 32'h0 : w_rdata;
                rspError <= r_err;
            end else if ((r_state == RESP) && rspReady) begin
                rspRdata <= '0;
                rspError <= 1'b0;
            end
        end
    end

    // Faulting requests never touch the array, even if the truncated index aliases.
    assign w_lane_we = (w_commit && r_write && !r_err) ? r_byte_en : '0;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clock   (clock),
        .lane_we (w_lane_we),
        .addr    (r_word_idx),
        .wdata   (r_wdata),
        .rdata   (w_rdata)
    );

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for CPU load/store traffic. Accepts one request at a time from the datapath over a valid/ready handshake and services it against a local word array after a fixed, parameterised latency. Returns read data, or a write acknowledge, over a second valid/ready handshake. It replaces the zero-latency data memory so the datapath and its future multicycle controller can be exercised against realistic, stalling memory.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words in the array; power of two, ≥ 4
- LATENCY, 2: cycles from request acceptance to response valid; ≥ 1
- clock  in  1  rising-edge clock
- resetN  in  1  asynchronous, active-low reset
- reqValid  in  1  request present
- reqReady  out  1  responder can accept a request
- reqWrite  in  1  1 = store, 0 = load
- reqAddr  in  32  byte address
- reqWdata  in  32  store data
- reqByteEn  in  4  byte lane enables; bit i covers bits 8i+7:8i
- rspValid  out  1  response present
- rspReady  in  1  requester takes the response
- rspRdata  out  32  load data; 0 for stores and errors
- rspError  out  1  request was misaligned or out of range

## Operation
- States: IDLE, BUSY, RESP. Reset state is IDLE.
- IDLE
  - reqReady = 1.
  - On reqValid, the responder latches reqWrite, reqAddr, reqWdata and reqByteEn.
  - It computes err = (reqAddr[1:0] != 0) or (reqAddr[31:2] ≥ DEPTH_WORDS).
  - It loads cnt = LATENCY-1 and moves to BUSY.
- BUSY
  - reqReady = 0.
  - If cnt != 0, decrement cnt.
  - If cnt == 0, perform the commit and move to RESP.
- Commit behaviour:
  - Load without err: rspRdata ← array[word index].
  - Store without err: each enabled lane is written to the array. rspRdata ← 0.
  - err: no array write, rspRdata ← 0, rspError ← 1.
- RESP
  - rspValid = 1. rspRdata and rspError are held stable until the cycle in which rspReady = 1.
  - At that edge the block returns to IDLE, clears rspError and rspRdata, and clears rspValid.
- Inputs on the request port are ignored outside IDLE.
- Read-after-write: a load accepted after a store's response sees the stored data.
- The array is not cleared by reset. A store that has not committed when reset asserts is discarded.

## Timing
- Reset values: reqReady = 1 once resetN deasserts. rspValid = 0, rspError = 0, rspRdata = 0. State is IDLE and cnt = 0.
- Accept handshake at edge N: the array commit and rspValid rising both occur at edge N+LATENCY.
- Response handshake at edge M: reqReady rises after M, and the earliest next accept is edge M+1.
- Minimum cycles per transaction is LATENCY+2.
- rspReady may be held high in advance. The response then completes at the first cycle of RESP.
- resetN asserted in any state forces the reset values immediately, without waiting for a clock edge.

## Configuration
- DMEM_BYTE_ENABLE_EN defined: stores write only the lanes selected by reqByteEn. A store with reqByteEn = 0 commits nothing but still responds normally.
- Not defined: reqByteEn is ignored, and every non-error store writes all 32 bits.

## Structure
- Package dmem_pkg holds:
  - the state enum typedef (IDLE, BUSY, RESP)
  - the byte-lane count constant (4)
  - a function computing the counter width from LATENCY
- Sub-module dmem_array: a DEPTH_WORDS × 32 array with combinational read, synchronous byte-lane write on clock, and no reset. The responder instantiates one copy.

## Test plan
- Reset, then idle: reqReady = 1, rspValid = 0, rspRdata = 0 → all held for 10 cycles with no request.
- Store 0xDEADBEEF to 0x10 with byteEn = 4'hF, then load from 0x10, LATENCY = 2 → rspValid rises 2 cycles after each accept. The load returns 0xDEADBEEF with rspError = 0.
- With DMEM_BYTE_ENABLE_EN defined: store 0x11223344 to 0x20, then store 0xAABBCCDD to 0x20 with byteEn = 4'b0101, then load 0x20 → returns 0x11BB33DD. Without the macro, the same sequence returns 0xAABBCCDD.
- Load from 0x13 (misaligned), and separately from byte address 4·DEPTH_WORDS → rspError = 1 and rspRdata = 0 in both cases. The array is unchanged, verified by reading back word 0.
- Backpressure: hold rspReady = 0 for 5 cycles in RESP while reqValid stays high → rspValid and rspRdata are held stable, reqReady = 0 throughout, and no second request is accepted until the edge after the handshake.
- Reset mid-operation: accept a store of 0x55 to 0x8 with LATENCY = 4, then assert resetN low 2 cycles later → outputs go to reset values immediately. A subsequent load of 0x8 returns the word's previous contents.
